// File: rtl/bus_chk_pkg.sv
// Shared constants and helpers for the bus packet checker: error bit positions
// and destination-id extraction from a packet.
package bus_chk_pkg;

    localparam int ERR_ILLEGAL  = 0;
    localparam int ERR_OVERFLOW = 1;
    localparam int ERR_ORPHAN   = 2;
    localparam int ERR_MISMATCH = 3;
    localparam int ERR_TIMEOUT  = 4;
    localparam int ERR_W        = 5;

    localparam int DEST_W    = 8;
    localparam int PKT_MAX_W = 64;

    // Destination id sits in the top byte of the packet; pkt_sz is the live width.
    function automatic logic [DEST_W-1:0] dest_of(input logic [PKT_MAX_W-1:0] pkt,
                                                  input int pkt_sz);
        return pkt[pkt_sz-1 -: DEST_W];
    endfunction

endpackage

// File: rtl/bus_pkt_checker_if.sv
// Tap of the packet bus seen by the checker: send side and deliver side.
// The bus model drives it (master); the checker only observes (slave).
interface bus_pkt_checker_if #(
    parameter int DRVRS   = 4,
    parameter int PCKG_SZ = 16
);
    logic                       snd_vld;
    logic [PCKG_SZ-1:0]         snd_pkt;
    logic                       rcv_vld;
    logic [$clog2(DRVRS)-1:0]   rcv_dev;
    logic [PCKG_SZ-1:0]         rcv_pkt;

    modport master (output snd_vld, snd_pkt, rcv_vld, rcv_dev, rcv_pkt);
    modport slave  (input  snd_vld, snd_pkt, rcv_vld, rcv_dev, rcv_pkt);
endinterface

// File: rtl/chk_fifo.sv
// Per-destination expected-packet FIFO. With CHK_LATENCY_EN defined each entry
// also carries the timestamp of its push.
module chk_fifo #(
    parameter int W     = 16,
    parameter int DEPTH = 4,
`ifdef CHK_LATENCY_EN
    parameter int TS_W  = 16,
`endif
    localparam int CW   = $clog2(DEPTH + 1)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            push,
    input  logic            pop,
    input  logic [W-1:0]    din,
`ifdef CHK_LATENCY_EN
    input  logic [TS_W-1:0] ts_in,
    output logic [TS_W-1:0] head_ts,
`endif
    output logic [W-1:0]    head,
    output logic            full,
    output logic            empty,
    output logic [CW-1:0]   count
);
    localparam int PTR_W = $clog2(DEPTH);

    logic [W-1:0]     mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr_reg;
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [CW-1:0]    count_reg;

    // The caller guarantees push only when not full (or popping) and pop only when not empty.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_reg] <= din;
        end
    end

`ifdef CHK_LATENCY_EN
    logic [TS_W-1:0] ts_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (push) begin
            ts_mem[wr_ptr_reg] <= ts_in;
        end
    end

    assign head_ts = ts_mem[rd_ptr_reg];
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            end
            count_reg <= count_reg + CW'(push) - CW'(pop);
        end
    end

    // Head is read asynchronously so the receive compare happens in the event cycle.
    assign head  = mem[rd_ptr_reg];
    assign full  = (count_reg == CW'(DEPTH));
    assign empty = (count_reg == '0);
    assign count = count_reg;

endmodule

// File: rtl/bus_pkt_checker.sv
// In-line scoreboard for the N-device packet bus: one in-order expected FIFO per
// destination. Optional latency/timeout tracking is enabled by CHK_LATENCY_EN.
module bus_pkt_checker
    import bus_chk_pkg::*;
#(
    parameter int DRVRS   = 4,
    parameter int PCKG_SZ = 16,
    parameter int DEPTH   = 4,
    parameter int CNT_W   = 16,
    parameter int TS_W    = 16,
    parameter int TIMEOUT = 64
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic                                clr,
    bus_pkt_checker_if.slave                    bus,
    output logic [CNT_W-1:0]                    match_cnt,
    output logic [CNT_W-1:0]                    err_cnt,
    output logic [ERR_W-1:0]                    err_code,
    output logic [PCKG_SZ-1:0]                  last_exp,
    output logic [PCKG_SZ-1:0]                  last_got,
    output logic [$clog2(DRVRS*DEPTH+1)-1:0]    pending,
    output logic                                done,
    output logic [TS_W-1:0]                     lat_max
);
    localparam int DEV_W  = $clog2(DRVRS);
    localparam int PEND_W = $clog2(DRVRS*DEPTH+1);
    localparam int FCNT_W = $clog2(DEPTH+1);
    localparam int EVT_W  = 5;

    logic [PCKG_SZ-1:0] snd_pkt;
    logic [PCKG_SZ-1:0] rcv_pkt;
    logic [DEST_W-1:0]  snd_dest;
    logic               dest_legal;

    logic [DRVRS-1:0]   push_req;
    logic [DRVRS-1:0]   push_vec;
    logic [DRVRS-1:0]   pop_vec;
    logic [DRVRS-1:0]   full_vec;
    logic [DRVRS-1:0]   empty_vec;
    logic [DRVRS-1:0]   tout_vec;
    logic [PCKG_SZ-1:0] head_arr  [DRVRS];
    logic [FCNT_W-1:0]  count_arr [DRVRS];
    logic [PCKG_SZ-1:0] head_sel;

    logic evt_illegal, evt_overflow, evt_orphan, evt_match, evt_mismatch;
    logic [EVT_W-1:0] tout_cnt;
    logic [EVT_W-1:0] n_err;
    logic [CNT_W:0]   err_sum;

    logic [CNT_W-1:0]   match_cnt_reg, match_cnt_next;
    logic [CNT_W-1:0]   err_cnt_reg, err_cnt_next;
    logic [ERR_W-1:0]   err_code_reg, err_code_next;
    logic [PCKG_SZ-1:0] last_exp_reg, last_got_reg;
    logic [PEND_W-1:0]  pending_sum;

    assign snd_pkt    = bus.snd_pkt;
    assign rcv_pkt    = bus.rcv_pkt;
    assign snd_dest   = dest_of(PKT_MAX_W'(snd_pkt), PCKG_SZ);
    assign dest_legal = (snd_dest < DEST_W'(DRVRS));

`ifdef CHK_LATENCY_EN
    logic [TS_W-1:0] ts_reg;
    logic [TS_W-1:0] head_ts_arr [DRVRS];
    logic [TS_W-1:0] head_ts_sel;
    logic [TS_W-1:0] lat_now;
    logic [TS_W-1:0] lat_max_reg;
    logic [DRVRS-1:0] tout_flag_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            ts_reg <= '0;
        end else begin
            ts_reg <= ts_reg + TS_W'(1);
        end
    end
`endif

    for (genvar gi = 0; gi < DRVRS; gi++) begin : g_dest
        assign push_req[gi] = bus.snd_vld && dest_legal && (snd_dest == DEST_W'(gi));
        assign pop_vec[gi]  = bus.rcv_vld && (bus.rcv_dev == DEV_W'(gi)) && !empty_vec[gi];
        // A full FIFO still accepts a push when its head leaves in the same cycle.
        assign push_vec[gi] = push_req[gi] && (!full_vec[gi] || pop_vec[gi]);

        chk_fifo #(
            .W     (PCKG_SZ),
`ifdef CHK_LATENCY_EN
            .TS_W  (TS_W),
`endif
            .DEPTH (DEPTH)
        ) u_fifo (
            .clk     (clk),
            .reset   (reset),
            .push    (push_vec[gi]),
            .pop     (pop_vec[gi]),
            .din     (snd_pkt),
`ifdef CHK_LATENCY_EN
            .ts_in   (ts_reg),
            .head_ts (head_ts_arr[gi]),
`endif
            .head    (head_arr[gi]),
            .full    (full_vec[gi]),
            .empty   (empty_vec[gi]),
            .count   (count_arr[gi])
        );

`ifdef CHK_LATENCY_EN
        logic [TS_W-1:0] age;
        assign age          = ts_reg - head_ts_arr[gi];
        assign tout_vec[gi] = !empty_vec[gi] && !tout_flag_reg[gi] && (age > TS_W'(TIMEOUT));

        // One timeout report per entry: the flag re-arms when the head is popped.
        always_ff @(posedge clk) begin
            if (reset || pop_vec[gi]) begin
                tout_flag_reg[gi] <= 1'b0;
            end else if (tout_vec[gi]) begin
                tout_flag_reg[gi] <= 1'b1;
            end
        end
`else
        assign tout_vec[gi] = 1'b0;
`endif
    end

    always_comb begin
        head_sel = '0;
        for (int i = 0; i < DRVRS; i++) begin
            if (bus.rcv_dev == DEV_W'(i)) begin
                head_sel = head_arr[i];
            end
        end
    end

    always_comb begin
        tout_cnt    = '0;
        pending_sum = '0;
        for (int i = 0; i < DRVRS; i++) begin
            tout_cnt    = tout_cnt + EVT_W'(tout_vec[i]);
            pending_sum = pending_sum + PEND_W'(count_arr[i]);
        end
    end

    // An out-of-range rcv_dev has no FIFO, so it is reported as an orphan too.
    assign evt_illegal  = bus.snd_vld && !dest_legal;
    assign evt_overflow = |(push_req & full_vec & ~pop_vec);
    assign evt_orphan   = bus.rcv_vld && !(|pop_vec);
    assign evt_match    = (|pop_vec) && (head_sel == rcv_pkt);
    assign evt_mismatch = (|pop_vec) && (head_sel != rcv_pkt);

    always_comb begin
        err_code_next = err_code_reg;
        err_code_next[ERR_ILLEGAL]  = err_code_reg[ERR_ILLEGAL]  | evt_illegal;
        err_code_next[ERR_OVERFLOW] = err_code_reg[ERR_OVERFLOW] | evt_overflow;
        err_code_next[ERR_ORPHAN]   = err_code_reg[ERR_ORPHAN]   | evt_orphan;
        err_code_next[ERR_MISMATCH] = err_code_reg[ERR_MISMATCH] | evt_mismatch;
        err_code_next[ERR_TIMEOUT]  = err_code_reg[ERR_TIMEOUT]  | (|tout_vec);

        n_err = EVT_W'(evt_illegal | evt_overflow)
              + EVT_W'(evt_orphan | evt_mismatch)
              + tout_cnt;
        err_sum      = {1'b0, err_cnt_reg} + (CNT_W+1)'(n_err);
        err_cnt_next = err_sum[CNT_W] ? '1 : err_sum[CNT_W-1:0];

        match_cnt_next = match_cnt_reg;
        if (evt_match && !(&match_cnt_reg)) begin
            match_cnt_next = match_cnt_reg + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset || clr) begin
            match_cnt_reg <= '0;
            err_cnt_reg   <= '0;
            err_code_reg  <= '0;
            last_exp_reg  <= '0;
            last_got_reg  <= '0;
        end else begin
            match_cnt_reg <= match_cnt_next;
            err_cnt_reg   <= err_cnt_next;
            err_code_reg  <= err_code_next;
            if (evt_mismatch) begin
                last_exp_reg <= head_sel;
                last_got_reg <= rcv_pkt;
            end
        end
    end

`ifdef CHK_LATENCY_EN
    always_comb begin
        head_ts_sel = '0;
        for (int i = 0; i < DRVRS; i++) begin
            if (bus.rcv_dev == DEV_W'(i)) begin
                head_ts_sel = head_ts_arr[i];
            end
        end
    end

    assign lat_now = ts_reg - head_ts_sel;

    always_ff @(posedge clk) begin
        if (reset || clr) begin
            lat_max_reg <= '0;
        end else if (evt_match && (lat_now > lat_max_reg)) begin
            lat_max_reg <= lat_now;
        end
    end

    assign lat_max = lat_max_reg;
`else
    logic unused_cfg;
    assign unused_cfg = ^TIMEOUT;
    assign lat_max    = '0;
`endif

    assign match_cnt = match_cnt_reg;
    assign err_cnt   = err_cnt_reg;
    assign err_code  = err_code_reg;
    assign last_exp  = last_exp_reg;
    assign last_got  = last_got_reg;
    assign pending   = pending_sum;
    assign done      = (pending_sum == '0) && (err_code_reg == '0);

endmodule

// File: tb/tb_bus_pkt_checker.sv
// Directed bench for bus_pkt_checker (DRVRS=4, PCKG_SZ=16, DEPTH=4, TIMEOUT=20);
// latency expectations follow CHK_LATENCY_EN.
module tb_bus_pkt_checker;
    import bus_chk_pkg::*;

`ifdef CHK_LATENCY_EN
    localparam bit LAT_EN = 1'b1;
`else
    localparam bit LAT_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        clr = 1'b0;
    logic [15:0] match_cnt, err_cnt, last_exp, last_got, lat_max;
    logic [4:0]  err_code;
    logic [4:0]  pending;
    logic        done;

    int n_chk = 0;
    int n_pass = 0;

    bus_pkt_checker_if #(.DRVRS(4), .PCKG_SZ(16)) bus_if ();

    bus_pkt_checker #(
        .DRVRS(4), .PCKG_SZ(16), .DEPTH(4), .CNT_W(16), .TS_W(16), .TIMEOUT(20)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .clr       (clr),
        .bus       (bus_if.slave),
        .match_cnt (match_cnt),
        .err_cnt   (err_cnt),
        .err_code  (err_code),
        .last_exp  (last_exp),
        .last_got  (last_got),
        .pending   (pending),
        .done      (done),
        .lat_max   (lat_max)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One bus cycle; called at posedge+1, returns at the next posedge+1.
    task automatic step(input logic sv, input logic [15:0] sp,
                        input logic rv, input logic [1:0] rd, input logic [15:0] rp);
        bus_if.snd_vld = sv;
        bus_if.snd_pkt = sp;
        bus_if.rcv_vld = rv;
        bus_if.rcv_dev = rd;
        bus_if.rcv_pkt = rp;
        @(posedge clk);
        #1;
        bus_if.snd_vld = 1'b0;
        bus_if.rcv_vld = 1'b0;
        if (sv || rv || clr || reset) begin
            $display("t=%0t snd=%0b:%h rcv=%0b:d%0d:%h clr=%0b rst=%0b -> match=%0d err=%0d code=%b pend=%0d done=%0b",
                     $time, sv, sp, rv, rd, rp, clr, reset,
                     match_cnt, err_cnt, err_code, pending, done);
        end
    endtask

    task automatic snd(input logic [15:0] p);
        step(1'b1, p, 1'b0, 2'd0, 16'h0);
    endtask

    task automatic rcv(input logic [1:0] d, input logic [15:0] p);
        step(1'b0, 16'h0, 1'b1, d, p);
    endtask

    task automatic do_clr();
        clr = 1'b1;
        step(1'b0, 16'h0, 1'b0, 2'd0, 16'h0);
        clr = 1'b0;
    endtask

    initial begin
        bus_if.snd_vld = 1'b0;
        bus_if.snd_pkt = '0;
        bus_if.rcv_vld = 1'b0;
        bus_if.rcv_dev = '0;
        bus_if.rcv_pkt = '0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;

        check_eq("rst_match", match_cnt, 0);
        check_eq("rst_err", err_cnt, 0);
        check_eq("rst_code", err_code, 0);
        check_eq("rst_pending", pending, 0);
        check_eq("rst_done", done, 1);
        check_eq("rst_lat", lat_max, 0);

        // 1: in-order delivery to three devices
        snd(16'h00FF); snd(16'h01AB); snd(16'h02CC); snd(16'h00DA);
        check_eq("t1_pend4", pending, 4);
        check_eq("t1_notdone", done, 0);
        rcv(2'd0, 16'h00FF); rcv(2'd1, 16'h01AB); rcv(2'd2, 16'h02CC); rcv(2'd0, 16'h00DA);
        check_eq("t1_match", match_cnt, 4);
        check_eq("t1_err", err_cnt, 0);
        check_eq("t1_pend0", pending, 0);
        check_eq("t1_done", done, 1);

        // 2: payload mismatch
        do_clr();
        check_eq("t2_clr_match", match_cnt, 0);
        snd(16'h0011);
        rcv(2'd0, 16'h0012);
        check_eq("t2_code", err_code, 5'b01000);
        check_eq("t2_exp", last_exp, 16'h0011);
        check_eq("t2_got", last_got, 16'h0012);
        check_eq("t2_err", err_cnt, 1);
        check_eq("t2_match", match_cnt, 0);
        check_eq("t2_done", done, 0);

        // 3: orphan on empty FIFO, then clear
        do_clr();
        rcv(2'd3, 16'h0300);
        check_eq("t3_code", err_code, 5'b00100);
        check_eq("t3_err", err_cnt, 1);
        check_eq("t3_pend", pending, 0);
        do_clr();
        check_eq("t3_clr_code", err_code, 0);
        check_eq("t3_clr_err", err_cnt, 0);
        check_eq("t3_clr_exp", last_exp, 0);
        check_eq("t3_done", done, 1);

        // 4: overflow then illegal destination
        snd(16'h0101); snd(16'h0102); snd(16'h0103); snd(16'h0104);
        check_eq("t4_noovf", err_code, 0);
        snd(16'h0105);
        check_eq("t4_ovf_code", err_code, 5'b00010);
        check_eq("t4_pend", pending, 4);
        check_eq("t4_ovf_err", err_cnt, 1);
        snd(16'h07AA);
        check_eq("t4_ill_code", err_code, 5'b00011);
        check_eq("t4_ill_err", err_cnt, 2);
        rcv(2'd1, 16'h0101); rcv(2'd1, 16'h0102); rcv(2'd1, 16'h0103); rcv(2'd1, 16'h0104);
        check_eq("t4_drain_match", match_cnt, 4);
        check_eq("t4_drain_err", err_cnt, 2);
        check_eq("t4_drain_pend", pending, 0);

        // 5: full + push + pop, then empty + push + pop
        do_clr();
        snd(16'h0201); snd(16'h0202); snd(16'h0203); snd(16'h0204);
        step(1'b1, 16'h02EE, 1'b1, 2'd2, 16'h0201);
        check_eq("t5_full_code", err_code, 0);
        check_eq("t5_full_pend", pending, 4);
        check_eq("t5_full_match", match_cnt, 1);
        rcv(2'd2, 16'h0202); rcv(2'd2, 16'h0203); rcv(2'd2, 16'h0204); rcv(2'd2, 16'h02EE);
        check_eq("t5_drain_match", match_cnt, 5);
        check_eq("t5_drain_pend", pending, 0);
        step(1'b1, 16'h0201, 1'b1, 2'd2, 16'h0201);
        check_eq("t5_empty_code", err_code, 5'b00100);
        check_eq("t5_empty_err", err_cnt, 1);
        check_eq("t5_empty_pend", pending, 1);
        rcv(2'd2, 16'h0201);
        check_eq("t5_late_match", match_cnt, 6);
        check_eq("t5_late_pend", pending, 0);
        do_clr();
        step(1'b1, 16'h09AA, 1'b1, 2'd3, 16'h0300);
        check_eq("t5_dual_err", err_cnt, 2);
        check_eq("t5_dual_code", err_code, 5'b00101);
        check_eq("t5_dual_lat", lat_max, 0);

        // 6: head waits past TIMEOUT, latency of the late match, reset mid-run
        reset = 1'b1;
        step(1'b0, 16'h0, 1'b0, 2'd0, 16'h0);
        reset = 1'b0;
        snd(16'h0301);
        repeat (25) step(1'b0, 16'h0, 1'b0, 2'd0, 16'h0);
        check_eq("t6_to_code", err_code, LAT_EN ? 5'b10000 : 5'b00000);
        check_eq("t6_to_err", err_cnt, LAT_EN ? 1 : 0);
        check_eq("t6_pend", pending, 1);
        rcv(2'd3, 16'h0301);
        check_eq("t6_match", match_cnt, 1);
        check_eq("t6_lat", lat_max, LAT_EN ? 26 : 0);
        check_eq("t6_err_once", err_cnt, LAT_EN ? 1 : 0);
        snd(16'h0105);
        rcv(2'd0, 16'h0000);
        reset = 1'b1;
        step(1'b1, 16'h0102, 1'b0, 2'd0, 16'h0);
        check_eq("t6_rst_match", match_cnt, 0);
        check_eq("t6_rst_err", err_cnt, 0);
        check_eq("t6_rst_code", err_code, 0);
        check_eq("t6_rst_pend", pending, 0);
        check_eq("t6_rst_lat", lat_max, 0);
        check_eq("t6_rst_done", done, 1);
        reset = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
